gate_reduce_unit: RTL and testbench

Parametrised, registered successor to the two-input OR gate. It reduces a packet of WIDTH-bit words into one result word, applying a bitwise operation selected per packet (OR, AND, XOR or NOR) across all beats. Input and output use valid/ready handshakes. It sits between a stimulus/packet source and a result consumer in the FPGA introduction designs, and is exercised by a self-checking VCD-dumping bench.

---
 rtl/gate_reduce_unit.sv | 115 +++++++++++
 tb/tb_gate_reduce_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_reduce_unit.sv
// Packet reducer: folds every beat of a packet into one word with OR/AND/XOR/NOR,
// then presents the result and the (saturating) beat count on a valid/ready output.
module gate_reduce_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;

    assign accept = in_valid && in_ready_q;

    // NOR folds as OR; the inversion is applied only when the result is presented.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fold
            assign acc_d[gi] = (op_q == 2'b01) ? (acc_q[gi] & in_data[gi]) :
                               (op_q == 2'b10) ? (acc_q[gi] ^ in_data[gi]) :
                                                 (acc_q[gi] | in_data[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= 2'b00;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc_q <= in_data;
                        op_q  <= in_op;
                        cnt_q <= CNT_ONE;
                        sat_q <= 1'b0;
                        if (in_last) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        if (&cnt_q) begin
                            sat_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                        if (in_last) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Result fields read as zero whenever no result is being presented.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? ((op_q == 2'b11) ? ~acc_q : acc_q) : '0;
    assign out_count = out_valid_q ? cnt_q : '0;
    assign out_sat   = out_valid_q & sat_q;

endmodule

// File: tb/tb_gate_reduce_unit.sv
// Directed bench: two instances (CNT_W=8 and CNT_W=2) share stimulus; each has its own
// expected-result queue drained by an independent output monitor.
module tb_gate_reduce_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic [1:0] in_op;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_sat_a;
    logic [7:0] out_data_a, out_count_a;
    logic       in_ready_b, out_valid_b, out_sat_b;
    logic [7:0] out_data_b;
    logic [1:0] out_count_b;

    typedef struct {
        logic [7:0] data;
        int         cnt;
        logic       sat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_reduce_unit #(.WIDTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .in_op(in_op),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_count(out_count_a), .out_sat(out_sat_a)
    );

    gate_reduce_unit #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .in_op(in_op),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_count(out_count_b), .out_sat(out_sat_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // cnt_b/sat_b are the hand-computed values for the 2-bit counter instance.
    task automatic expect_pkt(input logic [7:0] data, input int cnt_a, input int cnt_b, input logic sat_b);
        exp_t e;
        e.data = data; e.cnt = cnt_a; e.sat = 1'b0;
        q_a.push_back(e);
        e.cnt = cnt_b; e.sat = sat_b;
        q_b.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid_a && out_ready) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_result", 64'(out_data_a), 64'hDEAD);
            end else begin
                e = q_a.pop_front();
                $display("t=%0t dut_a result data=%02h count=%0d sat=%0b", $time, out_data_a, out_count_a, out_sat_a);
                chk("a_out_data", 64'(out_data_a), 64'(e.data));
                chk("a_out_count", 64'(out_count_a), 64'(e.cnt));
                chk("a_out_sat", 64'(out_sat_a), 64'(e.sat));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid_b && out_ready) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_result", 64'(out_data_b), 64'hDEAD);
            end else begin
                e = q_b.pop_front();
                $display("t=%0t dut_b result data=%02h count=%0d sat=%0b", $time, out_data_b, out_count_b, out_sat_b);
                chk("b_out_data", 64'(out_data_b), 64'(e.data));
                chk("b_out_count", 64'(out_count_b), 64'(e.cnt));
                chk("b_out_sat", 64'(out_sat_b), 64'(e.sat));
            end
        end
    end

    // Present one beat; returns 1 ns after the accepting edge with in_valid dropped.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic [1:0] op);
        int tries;
        in_valid = 1'b1; in_data = d; in_last = last; in_op = op;
        tries = 0;
        while (!in_ready_a && tries < 20) begin
            @(posedge clk); #1;
            tries++;
        end
        if (tries >= 20) chk("beat_accept_timeout", 64'(in_ready_a), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_data", 64'(out_data_a), 64'd0);
        chk("rst_out_count", 64'(out_count_a), 64'd0);
        chk("rst_in_ready", 64'(in_ready_a), 64'd0);
        q_a.delete();
        q_b.delete();
        #2;
        rst_n = 1'b1;
        idle_cycle();
        chk("rst_release_in_ready", 64'(in_ready_a), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_op = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready_a), 64'd0);
        chk("reset_out_valid", 64'(out_valid_a), 64'd0);
        chk("reset_out_data", 64'(out_data_a), 64'd0);
        chk("reset_out_count", 64'(out_count_a), 64'd0);
        chk("reset_out_sat", 64'(out_sat_a), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready_before_clk", 64'(in_ready_a), 64'd0);
        @(posedge clk); #1;
        chk("release_in_ready_after_clk", 64'(in_ready_a), 64'd1);

        // OR 01|10|80 = 91, valid exactly one cycle after the last beat
        expect_pkt(8'h91, 3, 3, 1'b0);
        send_beat(8'h01, 1'b0, 2'b00);
        send_beat(8'h10, 1'b0, 2'b01);
        send_beat(8'h80, 1'b1, 2'b10);
        chk("or_valid_after_last", 64'(out_valid_a), 64'd1);
        chk("or_in_ready_in_hold", 64'(in_ready_a), 64'd0);
        idle_cycle();
        chk("or_valid_one_cycle", 64'(out_valid_a), 64'd0);
        chk("or_in_ready_back", 64'(in_ready_a), 64'd1);

        // Back-to-back: AND F0&3C=30, XOR AA^FF^0F=5A, NOR ~00=FF
        expect_pkt(8'h30, 2, 2, 1'b0);
        expect_pkt(8'h5A, 3, 3, 1'b0);
        expect_pkt(8'hFF, 1, 1, 1'b0);
        send_beat(8'hF0, 1'b0, 2'b01);
        send_beat(8'h3C, 1'b1, 2'b11);
        send_beat(8'hAA, 1'b0, 2'b10);
        send_beat(8'hFF, 1'b0, 2'b00);
        send_beat(8'h0F, 1'b1, 2'b01);
        send_beat(8'h00, 1'b1, 2'b11);
        idle_cycle();

        // Back-pressure: result must hold for 5 cycles
        out_ready = 1'b0;
        expect_pkt(8'h3C, 1, 1, 1'b0);
        send_beat(8'h3C, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_valid", 64'(out_valid_a), 64'd1);
            chk("hold_out_data", 64'(out_data_a), 64'h3C);
            chk("hold_out_count", 64'(out_count_a), 64'd1);
            chk("hold_in_ready", 64'(in_ready_a), 64'd0);
            idle_cycle();
        end
        out_ready = 1'b1;
        idle_cycle();
        chk("hold_release_in_ready", 64'(in_ready_a), 64'd1);
        chk("hold_release_out_valid", 64'(out_valid_a), 64'd0);

        // XOR with idle gaps: 01^02^04^08 = 0F; 2-bit counter saturates
        expect_pkt(8'h0F, 4, 3, 1'b1);
        send_beat(8'h01, 1'b0, 2'b10); idle_cycle();
        send_beat(8'h02, 1'b0, 2'b00); idle_cycle();
        send_beat(8'h04, 1'b0, 2'b00); idle_cycle();
        send_beat(8'h08, 1'b1, 2'b00);
        idle_cycle();

        // Five OR beats of 01: 2-bit counter saturates at 3
        expect_pkt(8'h01, 5, 3, 1'b1);
        for (int i = 0; i < 5; i++) send_beat(8'h01, (i == 4), 2'b00);
        idle_cycle();

        // Reset while a result is held: valid must drop without a clock
        out_ready = 1'b0;
        send_beat(8'h77, 1'b1, 2'b00);
        chk("pre_reset_hold_valid", 64'(out_valid_a), 64'd1);
        pulse_reset();
        out_ready = 1'b1;

        // Reset after two beats of an open packet, then a fresh packet
        send_beat(8'hF0, 1'b0, 2'b00);
        send_beat(8'h0F, 1'b0, 2'b00);
        pulse_reset();
        expect_pkt(8'h55, 1, 1, 1'b0);
        send_beat(8'h55, 1'b1, 2'b00);
        idle_cycle();
        idle_cycle();

        chk("queue_a_drained", 64'(q_a.size()), 64'd0);
        chk("queue_b_drained", 64'(q_b.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
